// File: rtl/serial_tx_arbiter.sv
// Two-requester round-robin serial transmitter: start, 8 data bits LSB first, [odd parity], stop, gap.
// Define SERIAL_TX_PARITY_EN to include the odd parity bit; without it frames are 10 bits.
module serial_tx_arbiter #(
   parameter int IDLE_GAP = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       gnt0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       gnt1,
   output logic       out,
   output logic       busy,
   output logic       owner,
   output logic       done
);

   localparam logic       HAS_GAP  = (IDLE_GAP > 0);
   localparam logic [3:0] LAST_GAP = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      GAP    = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] gap_cnt_q, gap_cnt_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic       win;
   logic [7:0] pick;
`ifdef SERIAL_TX_PARITY_EN
   logic       parity_q, parity_d;
`endif

   // On a tie the requester that did not own the previous frame wins.
   always_comb begin
      win  = (req0 && req1) ? ~last_q : req1;
      pick = win ? data1 : data0;
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      owner_d   = owner_q;
      last_d    = last_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               shift_d  = pick;
`ifdef SERIAL_TX_PARITY_EN
               parity_d = ~^pick;
`endif
               owner_d  = win;
               last_d   = win;
               gnt0_d   = ~win;
               gnt1_d   = win;
               state_d  = START;
            end
         end
         START: begin
            bit_cnt_d = 3'd0;
            state_d   = DATA;
         end
         DATA: begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            state_d = STOP;
         end
`endif
         STOP: begin
            gap_cnt_d = 4'd0;
            if (HAS_GAP) begin
               state_d = GAP;
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt_q == LAST_GAP) begin
               gap_cnt_d = 4'd0;
               state_d   = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= 8'd0;
         bit_cnt_q <= 3'd0;
         gap_cnt_q <= 4'd0;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
`ifdef SERIAL_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // Line value depends only on registered state, never on the inputs.
   always_comb begin
      out = 1'b1;
      case (state_q)
         START:   out = 1'b0;
         DATA:    out = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
         PARITY:  out = parity_q;
`endif
         default: out = 1'b1;
      endcase
   end

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == STOP);
   assign owner = owner_q;
   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: table-driven frames, hand-written corner sequences, random run vs. a frame model.
module tb_serial_tx_arbiter;
  localparam int GAP = 1;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  localparam int SPACING = FL + GAP + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] data0 = 8'd0;
  logic [7:0] data1 = 8'd0;
  logic       gnt0, gnt1, out, busy, owner, done;

  int total = 0;
  int bad = 0;

  serial_tx_arbiter #(.IDLE_GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .data1(data1), .gnt1(gnt1),
    .out(out), .busy(busy), .owner(owner), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_first;
    logic       r0;
    logic [7:0] d0;
    logic       r1;
    logic [7:0] d1;
    logic       e_g0;
    logic       e_g1;
    logic [7:0] e_byte;
    logic       e_par;
  } vec_t;
  vec_t vecs[9];

  // Reference model: frame position counter plus a precomputed bit list.
  int         m_pos = -1;
  logic       m_last = 1'b1;
  logic       m_owner = 1'b0;
  logic       m_g0 = 1'b0;
  logic       m_g1 = 1'b0;
  int         m_bits[16];
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("rst out", out, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst owner", owner, 0);
    check("rst gnt", {gnt0, gnt1}, 0);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] b;
    b = v.e_byte;
    if (v.rst_first) do_reset();
    req0 = v.r0; data0 = v.d0; req1 = v.r1; data1 = v.d1;
    @(negedge clk);
    check($sformatf("v%0d gnt", idx), {gnt0, gnt1}, {v.e_g0, v.e_g1});
    check($sformatf("v%0d owner", idx), owner, v.e_g1);
    check($sformatf("v%0d start", idx), {out, busy}, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("v%0d bit%0d", idx, k), {out, done}, {b[k], 1'b0});
    end
`ifdef SERIAL_TX_PARITY_EN
    @(negedge clk);
    check($sformatf("v%0d parity", idx), {out, done}, {v.e_par, 1'b0});
`endif
    @(negedge clk);
    check($sformatf("v%0d stop", idx), {out, done, busy}, 3'b111);
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      check($sformatf("v%0d gap", idx), {out, done, busy}, 3'b101);
    end
    @(negedge clk);
    check($sformatf("v%0d idle", idx), {out, busy, gnt0, gnt1}, 4'b1000);
  endtask

  task automatic model_step();
    logic       w;
    logic [7:0] b;
    int         ones;
    m_g0 = 1'b0;
    m_g1 = 1'b0;
    if (reset) begin
      m_pos = -1; m_last = 1'b1; m_owner = 1'b0;
    end else if (m_pos < 0) begin
      if (req0 || req1) begin
        if (req0 && req1) w = !m_last;
        else w = req1;
        b = w ? data1 : data0;
        ones = 0;
        m_bits[0] = 0;
        for (int k = 0; k < 8; k++) begin
          m_bits[1 + k] = int'(b[k]);
          ones += int'(b[k]);
        end
`ifdef SERIAL_TX_PARITY_EN
        m_bits[9] = (ones % 2 == 0) ? 1 : 0;
`endif
        m_bits[FL - 1] = 1;
        m_pos = 0; m_owner = w; m_last = w;
        if (w) m_g1 = 1'b1;
        else m_g0 = 1'b1;
      end
    end else begin
      m_pos++;
      if (m_pos >= FL + GAP) m_pos = -1;
    end
    exp_q.push_back({(m_pos < 0) ? 1'b1 : (m_pos < FL ? m_bits[m_pos][0] : 1'b1),
                     m_pos >= 0, m_pos == FL - 1, m_owner, m_g0, m_g1});
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 8'h11, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 8'h33, 1'b1, 8'h44, 1'b0, 1'b1, 8'h44, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 8'h5A, 1'b1, 8'h0F, 1'b1, 1'b0, 8'h5A, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h7E, 1'b0, 1'b1, 8'h7E, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1, 1'b0, 8'hC3, 1'b1};

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset in the 5th frame cycle aborts the frame; a held req0 gets a fresh grant.
    req0 = 1'b1; data0 = 8'h3C;
    @(negedge clk);
    check("abort gnt", {gnt0, gnt1}, 2'b10);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort line", {out, busy, done}, 3'b100);
    check("abort no gnt", {gnt0, gnt1}, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    check("regrant gnt", {gnt0, gnt1}, 2'b10);
    check("regrant start", {out, busy, owner}, 3'b010);
    req0 = 1'b0;
    wait_idle("abort idle timeout");

    // Request raised mid-frame waits for the first IDLE edge.
    req1 = 1'b1; data1 = 8'h96;
    @(negedge clk);
    check("mid gnt1", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    req0 = 1'b1; data0 = 8'h69;
    for (int k = 4; k <= FL + GAP; k++) begin
      @(negedge clk);
      check($sformatf("mid hold c%0d", k), {busy, gnt0}, 2'b10);
    end
    @(negedge clk);
    check("mid idle", {busy, gnt0}, 2'b00);
    @(negedge clk);
    check("mid late gnt", {gnt0, gnt1, owner, out}, 4'b1000);
    req0 = 1'b0;
    wait_idle("mid idle timeout");

    // Both held: grants alternate, starting with requester 1 (requester 0 owned last).
    req0 = 1'b1; data0 = 8'h11; req1 = 1'b1; data1 = 8'h22;
    for (int t = 1; t <= 4 * SPACING; t++) begin
      int   ph;
      logic w;
      @(negedge clk);
      ph = (t - 1) % SPACING;
      w = (((t - 1) / SPACING) % 2 == 0);
      check($sformatf("alt t%0d gnt", t), {gnt0, gnt1},
            {ph == 0 && !w, ph == 0 && w});
      if (ph == 0) check($sformatf("alt t%0d owner", t), owner, w);
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("alt idle timeout");

    // Random traffic against the frame model.
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] e;
      @(posedge clk);
      model_step();
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("rand c%0d", c), {out, busy, done, owner, gnt0, gnt1}, e);
      reset = ($urandom_range(0, 149) == 0);
      if (m_g0) begin
        if ($urandom_range(0, 1) == 1) req0 = 1'b0;
        else data0 = 8'($urandom);
      end else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1'b1; data0 = 8'($urandom);
      end
      if (m_g1) begin
        if ($urandom_range(0, 1) == 1) req1 = 1'b0;
        else data1 = 8'($urandom);
      end else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1'b1; data1 = 8'($urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
